// File: rtl/mem_access_pkg.sv
// Shared definitions for the Y86-64 memory stage: instruction codes, FSM encoding
// and the icode -> memory-operation decode.
package mem_access_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_kind_t;

  typedef struct packed {
    op_kind_t kind;
    logic     addr_from_vala;  // ret/popq address the stack through valA
    logic     data_from_valp;  // call stores the return address
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [3:0] icode);
    mem_op_t op;
    op.kind           = OP_NONE;
    op.addr_from_vala = 1'b0;
    op.data_from_valp = 1'b0;
    case (icode)
      IRMMOVQ, IPUSHQ: op.kind = OP_WRITE;
      ICALL: begin
        op.kind           = OP_WRITE;
        op.data_from_valp = 1'b1;
      end
      IMRMOVQ: op.kind = OP_READ;
      IRET, IPOPQ: begin
        op.kind           = OP_READ;
        op.addr_from_vala = 1'b1;
      end
      default: op.kind = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide data memory bus: one byte per req/ack handshake.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_bounds_check.sv
// Combinational bounds check for a 64-bit access; 65-bit sum so a base near 2^64
// that would wrap is rejected rather than aliased to low memory.
module mem_bounds_check #(
  parameter int MEM_SIZE = 1024
) (
  input  logic [63:0] base,
  output logic        ok
);
  import mem_access_pkg::*;

  logic [64:0] end_addr;

  assign end_addr = {1'b0, base} + 65'(WORD_BYTES);
  assign ok       = (end_addr <= 65'(MEM_SIZE));
endmodule

// File: rtl/mem_access.sv
// Y86-64 memory stage: serialises a 64-bit little-endian load/store into eight
// byte handshakes, with bounds and per-byte timeout errors.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MEM_SIZE    = 1024,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    icode,
  input  logic [63:0]   valE,
  input  logic [63:0]   valA,
  input  logic [63:0]   valP,
  output logic          busy,
  output logic          done,
  output logic [63:0]   valM,
  output logic          dmem_error,
  mem_access_if.master  mem
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    state_reg;
  op_kind_t      kind_reg;
  logic [63:0]   base_reg;
  logic [63:0]   wdata_reg;
  logic [63:0]   rdata_reg;
  logic [2:0]    idx_reg;
  logic [TW-1:0] timer_reg;
  logic [63:0]   valm_reg;
  logic          err_reg;

  mem_op_t start_op;
  logic    bounds_ok;
  logic    in_xfer;

  assign start_op = decode_op(icode);
  assign in_xfer  = (state_reg == S_XFER);

  mem_bounds_check #(
    .MEM_SIZE(MEM_SIZE)
  ) u_bounds (
    .base(base_reg),
    .ok  (bounds_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      kind_reg  <= OP_NONE;
      base_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      idx_reg   <= '0;
      timer_reg <= '0;
      valm_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            kind_reg  <= start_op.kind;
            base_reg  <= start_op.addr_from_vala ? valA : valE;
            wdata_reg <= start_op.data_from_valp ? valP : valA;
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (kind_reg == OP_NONE) begin
            err_reg   <= 1'b0;
            state_reg <= S_DONE;
          end else if (!bounds_ok) begin
            err_reg   <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            idx_reg   <= '0;
            timer_reg <= '0;
            state_reg <= S_XFER;
          end
        end
        S_XFER: begin
          if (mem.mem_ack) begin
            if (kind_reg == OP_READ) begin
              rdata_reg[8*idx_reg +: 8] <= mem.mem_rdata;
            end
            if (idx_reg == 3'd7) begin
              // valM must already be valid during the done cycle, so the last
              // byte is merged straight from the bus rather than from rdata_reg.
              if (kind_reg == OP_READ) begin
                valm_reg <= {mem.mem_rdata, rdata_reg[55:0]};
              end
              err_reg   <= 1'b0;
              state_reg <= S_DONE;
            end else begin
              idx_reg   <= idx_reg + 3'd1;
              timer_reg <= '0;
            end
          end else if (timer_reg == TIMER_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign valM       = valm_reg;
  assign dmem_error = err_reg;

  // Bus outputs derive from the state register, so an async reset drops mem_req at once.
  assign mem.mem_req   = in_xfer;
  assign mem.mem_we    = in_xfer && (kind_reg == OP_WRITE);
  assign mem.mem_addr  = in_xfer ? (base_reg + 64'(idx_reg)) : '0;
  assign mem.mem_wdata = (in_xfer && (kind_reg == OP_WRITE)) ? wdata_reg[8*idx_reg +: 8] : '0;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: byte-wide memory model with programmable ack latency.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int MEM_SIZE    = 1024;
  localparam int TIMEOUT_CYC = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE = '0;
  logic [63:0] valA = '0;
  logic [63:0] valP = '0;
  logic        busy, done, dmem_error;
  logic [63:0] valM;

  mem_access_if bus();

  mem_access #(
    .MEM_SIZE   (MEM_SIZE),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .icode     (icode),
    .valE      (valE),
    .valA      (valA),
    .valP      (valP),
    .busy      (busy),
    .done      (done),
    .valM      (valM),
    .dmem_error(dmem_error),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  // Memory model: preload pattern mem[i] = i*7+3, bytes 0x10..0x17 = 01..08.
  logic [7:0]  mem [MEM_SIZE];
  logic [63:0] addr_log [256];
  int  lat = 0;
  bit  noack = 1'b0;
  bit  stray_ack = 1'b0;
  bit  loaded = 1'b0;
  int  wait_cnt = 0;
  int  xfer_total = 0;
  int  we_total = 0;
  int  unstable = 0;
  bit  prev_pending = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;
  logic        prev_we = 1'b0;

  assign bus.mem_ack   = (bus.mem_req && !noack && (wait_cnt == lat)) || stray_ack;
  assign bus.mem_rdata = (bus.mem_addr < 64'(MEM_SIZE)) ? mem[bus.mem_addr[9:0]] : 8'h00;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'(i * 7 + 3);
      for (int i = 0; i < 8; i++) mem[16 + i] <= 8'(i + 1);
      loaded <= 1'b1;
    end
    if (bus.mem_req && bus.mem_ack) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        we_total <= we_total + 1;
      end
      addr_log[xfer_total[7:0]] <= bus.mem_addr;
      xfer_total <= xfer_total + 1;
      wait_cnt <= 0;
    end else if (bus.mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
    if (bus.mem_req && !bus.mem_ack) begin
      if (prev_pending && (bus.mem_addr != prev_addr || bus.mem_we != prev_we ||
                           bus.mem_wdata != prev_wdata))
        unstable <= unstable + 1;
      prev_pending <= 1'b1;
      prev_addr    <= bus.mem_addr;
      prev_we      <= bus.mem_we;
      prev_wdata   <= bus.mem_wdata;
    end else begin
      prev_pending <= 1'b0;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int lat_seen, req_cyc, x0, w0, u0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse and count negedges until done (bounded); optionally
  // pulse a second start (a NOP) while busy at negedge number dup_at.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input int dup_at);
    @(negedge clk);
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    x0 = xfer_total; w0 = we_total; u0 = unstable;
    @(posedge clk);
    #1 start = 1'b0;
    lat_seen = -1;
    req_cyc = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (bus.mem_req) req_cyc++;
      if (c == dup_at) begin
        start = 1'b1; icode = INOP;
      end else if (c == dup_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat_seen = c;
        break;
      end
    end
    start = 1'b0;
    $display("op icode=%h valE=%h valA=%h: done after %0d cycles, valM=%h err=%0b, %0d bytes",
             ic, e, a, lat_seen, valM, dmem_error, xfer_total - x0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(bus.mem_req), 64'd0);
    check("rst_addr", bus.mem_addr, 64'd0);
    check("rst_valM", valM, 64'd0);
    check("rst_err", 64'(dmem_error), 64'd0);
    rst_n = 1'b1;

    // Stray ack with no request is ignored
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_xfers", 64'(xfer_total), 64'd0);

    // mrmovq 0x10, zero wait
    run_op(IMRMOVQ, 64'h10, 64'h0, 64'h0, 0);
    check("mr_lat", 64'(lat_seen), 64'd10);
    check("mr_valM", valM, 64'h0807060504030201);
    check("mr_err", 64'(dmem_error), 64'd0);
    check("mr_bytes", 64'(xfer_total - x0), 64'd8);
    check("mr_addr0", addr_log[x0], 64'h10);
    check("mr_addr7", addr_log[x0 + 7], 64'h17);
    check("mr_writes", 64'(we_total - w0), 64'd0);

    // pushq writes little-endian at the top of memory
    run_op(IPUSHQ, 64'h3F8, 64'h1122334455667788, 64'h0, 0);
    check("push_lat", 64'(lat_seen), 64'd10);
    check("push_err", 64'(dmem_error), 64'd0);
    check("push_writes", 64'(we_total - w0), 64'd8);
    check("push_m3f8", 64'(mem[10'h3F8]), 64'h88);
    check("push_m3fb", 64'(mem[10'h3FB]), 64'h55);
    check("push_m3ff", 64'(mem[10'h3FF]), 64'h11);
    check("push_valM_held", valM, 64'h0807060504030201);

    // Last legal word reads back
    run_op(IMRMOVQ, 64'h3F8, 64'h0, 64'h0, 0);
    check("edge_valM", valM, 64'h1122334455667788);
    check("edge_err", 64'(dmem_error), 64'd0);

    // One byte past the end: bounds error, no traffic
    run_op(IMRMOVQ, 64'h3F9, 64'h0, 64'h0, 0);
    check("oob_lat", 64'(lat_seen), 64'd2);
    check("oob_err", 64'(dmem_error), 64'd1);
    check("oob_req", 64'(req_cyc), 64'd0);
    check("oob_valM", valM, 64'h1122334455667788);

    // Address that would wrap past 2^64
    run_op(IMRMOVQ, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 0);
    check("wrap_lat", 64'(lat_seen), 64'd2);
    check("wrap_err", 64'(dmem_error), 64'd1);
    check("wrap_req", 64'(req_cyc), 64'd0);

    // No-op icode
    run_op(INOP, 64'h3F9, 64'h0, 64'h0, 0);
    check("nop_lat", 64'(lat_seen), 64'd2);
    check("nop_err", 64'(dmem_error), 64'd0);
    check("nop_req", 64'(req_cyc), 64'd0);

    // call stores valP; a second start while busy is ignored
    run_op(ICALL, 64'h100, 64'h0, 64'hCAFEF00DDEADBEEF, 3);
    check("call_lat", 64'(lat_seen), 64'd10);
    check("call_writes", 64'(we_total - w0), 64'd8);
    check("call_m100", 64'(mem[10'h100]), 64'hEF);
    repeat (3) @(negedge clk);
    check("dup_busy", 64'(busy), 64'd0);
    check("dup_xfers", 64'(xfer_total - x0), 64'd8);

    // ret with 3-cycle ack latency
    lat = 3;
    run_op(IRET, 64'h0, 64'h100, 64'h0, 0);
    lat = 0;
    check("ret_lat", 64'(lat_seen), 64'd34);
    check("ret_valM", valM, 64'hCAFEF00DDEADBEEF);
    check("ret_err", 64'(dmem_error), 64'd0);
    check("ret_stable", 64'(unstable - u0), 64'd0);

    // popq with no ack: timeout
    noack = 1'b1;
    run_op(IPOPQ, 64'h0, 64'h40, 64'h0, 0);
    noack = 1'b0;
    check("to_lat", 64'(lat_seen), 64'(TIMEOUT_CYC + 2));
    check("to_req", 64'(req_cyc), 64'(TIMEOUT_CYC));
    check("to_err", 64'(dmem_error), 64'd1);
    check("to_valM", valM, 64'hCAFEF00DDEADBEEF);
    check("to_bytes", 64'(xfer_total - x0), 64'd0);

    // rmmovq interrupted by reset while byte 4 is requested
    @(negedge clk);
    icode = IRMMOVQ; valE = 64'h80; valA = 64'hA1A2A3A4A5A6A7A8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat_seen = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 64'h84) begin
        lat_seen = c;
        break;
      end
    end
    check("rst_byte4_seen", 64'(lat_seen), 64'd6);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(bus.mem_req), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valM", valM, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_m83", 64'(mem[10'h83]), 64'hA5);
    check("midrst_m84", 64'(mem[10'h84]), 64'h9F);
    $display("reset during rmmovq byte 4: req=%0b busy=%0b", bus.mem_req, busy);

    run_op(IMRMOVQ, 64'h10, 64'h0, 64'h0, 0);
    check("post_lat", 64'(lat_seen), 64'd10);
    check("post_valM", valM, 64'h0807060504030201);
    check("post_err", 64'(dmem_error), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
